// File: rtl/segment_capture_decoder.sv
// Watches the multiplexed active-low segment/anode display bus and recovers the BCD
// value of each digit once the anode/segment pair has held steady for STABLE_CYCLES edges.
module segment_capture_decoder #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [DIGITS-1:0]                       anode_i,
    input  logic [7:0]                              segment_code_i,
    output logic [4*DIGITS-1:0]                     digits_bcd_o,
    output logic [DIGITS-1:0]                       digit_valid_o,
    output logic [DIGITS-1:0]                       dp_out_o,
    output logic                                    capture_stb_o,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] cap_index_o,
    output logic                                    code_err_o,
    output logic                                    frame_done_o
);

    localparam int unsigned IdxW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SampleW   = DIGITS + 8;
    localparam logic [7:0]  StableCnt = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StTrack, StHeld} state_e;

    state_e               state_q;
    logic [7:0]           cnt_q;
    logic [SampleW-1:0]   stored_q;
    logic [DIGITS-1:0]    mask_q;
    logic [4*DIGITS-1:0]  digits_q;
    logic [DIGITS-1:0]    valid_q;
    logic [DIGITS-1:0]    dp_q;
    logic                 capture_stb_q;
    logic [IdxW-1:0]      cap_index_q;
    logic                 code_err_q;
    logic                 frame_done_q;

    logic [SampleW-1:0]   sample;
    logic [DIGITS-1:0]    anode_low;
    int unsigned          n_low;
    logic [IdxW-1:0]      sel_idx;
    logic                 anode_legal;
    logic                 same;
    logic                 fresh;
    logic                 capture;
    logic [3:0]           dec_bcd;
    logic                 dec_blank;
    logic                 dec_err;
    logic [DIGITS-1:0]    mask_next;

    assign sample    = {anode_i, segment_code_i};
    assign anode_low = ~anode_i;
    assign same      = (sample == stored_q);

    always_comb begin
        n_low   = 0;
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (anode_low[i]) begin
                n_low   = n_low + 1;
                sel_idx = IdxW'(i);
            end
        end
    end

    assign anode_legal = (n_low == 1);

    // dp (bit 7) takes no part in matching.
    always_comb begin
        dec_bcd   = 4'hF;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        unique case (segment_code_i[6:0])
            7'h40:   dec_bcd = 4'd0;
            7'h79:   dec_bcd = 4'd1;
            7'h24:   dec_bcd = 4'd2;
            7'h30:   dec_bcd = 4'd3;
            7'h19:   dec_bcd = 4'd4;
            7'h12:   dec_bcd = 4'd5;
            7'h02:   dec_bcd = 4'd6;
            7'h78:   dec_bcd = 4'd7;
            7'h00:   dec_bcd = 4'd8;
            7'h10:   dec_bcd = 4'd9;
            7'h7F:   dec_blank = 1'b1;
            default: dec_err   = 1'b1;
        endcase
    end

    always_comb begin
        fresh   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle:  fresh = anode_legal;
            StTrack: begin
                if (anode_legal) begin
                    if (same) capture = ((cnt_q + 8'd1) == StableCnt);
                    else      fresh   = 1'b1;
                end
            end
            StHeld:  fresh = anode_legal && !same;
            default: fresh = 1'b0;
        endcase
        if (fresh && (StableCnt == 8'd1)) capture = 1'b1;
    end

    assign mask_next = mask_q | (DIGITS'(1) << sel_idx);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= 8'd0;
            stored_q      <= '0;
            mask_q        <= '0;
            digits_q      <= '1;
            valid_q       <= '0;
            dp_q          <= '0;
            capture_stb_q <= 1'b0;
            cap_index_q   <= '0;
            code_err_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            capture_stb_q <= 1'b0;
            code_err_q    <= 1'b0;
            frame_done_q  <= 1'b0;

            if (!anode_legal) begin
                state_q <= StIdle;
                cnt_q   <= 8'd0;
            end else if (fresh) begin
                stored_q <= sample;
                cnt_q    <= 8'd1;
                state_q  <= capture ? StHeld : StTrack;
            end else if (state_q == StTrack) begin
                cnt_q   <= cnt_q + 8'd1;
                state_q <= capture ? StHeld : StTrack;
            end

            if (capture) begin
                digits_q[4*sel_idx +: 4] <= dec_bcd;
                valid_q[sel_idx]         <= !dec_blank && !dec_err;
                dp_q[sel_idx]            <= ~segment_code_i[7];
                cap_index_q              <= sel_idx;
                capture_stb_q            <= 1'b1;
                code_err_q               <= dec_err;
                if (&mask_next) begin
                    frame_done_q <= 1'b1;
                    mask_q       <= '0;
                end else begin
                    mask_q       <= mask_next;
                end
            end
        end
    end

    assign digits_bcd_o  = digits_q;
    assign digit_valid_o = valid_q;
    assign dp_out_o      = dp_q;
    assign capture_stb_o = capture_stb_q;
    assign cap_index_o   = cap_index_q;
    assign code_err_o    = code_err_q;
    assign frame_done_o  = frame_done_q;

endmodule

// File: doc/segment_capture_decoder.md
Name: segment_capture_decoder

Overview:
- Inverse of the BCD-to-segment decoding path: watches the multiplexed, active-low segment/anode bus that drives the timer's display and recovers the BCD value of each digit.
- Each anode/segment combination is qualified by a stability window, then decoded back to BCD. Unknown codes are flagged.
- A strobe is raised per captured digit, and another when a full frame is complete.
- Used for display self-test and for loop-back checking of the timer datapath.

Parameters:
- DIGITS, 4, number of multiplexed digits; width of the anode bus.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- anode  input  DIGITS  active-low digit select; exactly one bit low means digit index i is selected.
- segment_code  input  8  active-low segment bus. Bit order is dp,g,f,e,d,c,b,a (bit7 = dp).
- digits_bcd  output  4*DIGITS  recovered BCD for digit i in [4*i+3:4*i]. The value 4'hF means blank or invalid.
- digit_valid  output  DIGITS  bit i set once digit i has captured a legal 0-9 code.
- dp_out  output  DIGITS  bit i is the decimal point of digit i at last capture; 1 = lit.
- capture_stb  output  1  one-cycle pulse on each capture.
- cap_index  output  $clog2(DIGITS) (min 1)  digit index of the most recent capture.
- code_err  output  1  one-cycle pulse, coincident with capture_stb, when the captured code is not legal.
- frame_done  output  1  one-cycle pulse when every digit has been captured at least once since the previous frame_done or reset.

Behaviour:
- Reset (rst_n low at a rising edge): all outputs are driven to these values.
  - digits_bcd = all 4'hF, digit_valid = 0, dp_out = 0.
  - capture_stb, code_err and frame_done = 0; cap_index = 0.
  - Internal: state = IDLE, counter = 0, frame-seen mask = 0.
  - Reset mid-dwell discards the partial count. No strobe is issued for the interrupted dwell.
- Legal codes are matched on bits [6:0] only; dp (bit7) is ignored for matching.
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, with bit7 = 1).
  - [6:0] = 7F is blank: digit becomes 4'hF, digit_valid[i] is cleared, and code_err is not raised.
  - Any other pattern is invalid: digit becomes 4'hF, digit_valid[i] is cleared, and code_err pulses.
- Each rising edge samples the pair {anode, segment_code}.
  - The anode is legal only when exactly one bit is 0.
  - Zero bits low, or two or more bits low, is illegal and forces state IDLE with counter = 0.
- State machine:
  - IDLE
    - Legal anode: load counter = 1, store the sample, go to TRACK.
    - If STABLE_CYCLES = 1, capture immediately and go to HELD.
  - TRACK
    - Sample equals stored: counter increments.
    - When counter reaches STABLE_CYCLES: capture on that same edge, go to HELD.
    - Sample differs but anode is legal: restart with counter = 1 on the new sample; stay in TRACK.
    - Illegal anode: go to IDLE.
  - HELD
    - Sample equal to stored: remain in HELD; no recapture while the combination persists.
    - Any change: treat as a fresh sample (same as the IDLE entry rules).
- Capture (registered outputs update on the capturing edge):
  - Write digits_bcd[i], digit_valid[i] and dp_out[i] (dp_out = ~segment_code[7]).
  - Set cap_index = i and pulse capture_stb.
  - Set bit i of the frame-seen mask.
  - If the mask becomes all ones on this edge: pulse frame_done on the same edge and clear the mask.
- Strobes are high for exactly one cycle and never back-to-back from a single dwell.
- Minimum spacing between two captures is STABLE_CYCLES cycles.
- Counter saturates at STABLE_CYCLES and never wraps.

Test Plan:
- Reset with STABLE_CYCLES=4, DIGITS=4 -> digits_bcd=16'hFFFF, digit_valid=0, and all strobes are 0.
- Hold anode=4'b1110, segment_code=8'hA4 for 10 cycles -> exactly one capture_stb, on the 4th sampling edge. Results: cap_index=0, digits_bcd[3:0]=2, digit_valid[0]=1, dp_out[0]=0.
- Hold anode=4'b1011 for 3 cycles, then change segment_code from 8'h92 to 8'h12 and hold 4 cycles -> no capture after the first 3. Then one capture with digit 2 = 5, dp_out[2]=1.
- Hold anode=4'b0111, segment_code=8'hFF for 4 cycles -> capture with digits_bcd[15:12]=F, digit_valid[3]=0, code_err=0. Repeat with 8'hAA -> code_err pulses with capture_stb.
- Apply anode=4'b1100, then 4'b1111, for 8 cycles each -> no captures and state stays IDLE. Then scan digits 0..3 at 5 cycles each with codes C0, F9, A4, B0 -> digits_bcd=16'h3210 and frame_done pulses once, with digit 3's capture.
- Assert rst_n=0 after 2 matching cycles of a dwell, release it, and continue the same inputs -> capture occurs only after 4 further stable cycles following release.
